// File: rtl/fractal_sync_merge.sv
// Two-to-one barrier merge node of the fractal sync tree: pairs up east/north and
// west/south arrivals per barrier ID, then completes locally or forwards one level up.
module fractal_sync_merge #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned LVL_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_valid_i,
    output logic                 en_ready_o,
    input  logic [ID_WIDTH-1:0]  en_id_i,
    input  logic [LVL_WIDTH-1:0] en_lvl_i,
    input  logic                 ws_valid_i,
    output logic                 ws_ready_o,
    input  logic [ID_WIDTH-1:0]  ws_id_i,
    input  logic [LVL_WIDTH-1:0] ws_lvl_i,
    output logic                 up_valid_o,
    input  logic                 up_ready_i,
    output logic [ID_WIDTH-1:0]  up_id_o,
    output logic [LVL_WIDTH-1:0] up_lvl_o,
    input  logic                 dn_valid_i,
    output logic                 dn_ready_o,
    input  logic [ID_WIDTH-1:0]  dn_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_WIDTH-1:0]  rsp_id_o,
    output logic [1:0]           rsp_sd_o,
    output logic                 lvl_err_o
);

    localparam int unsigned NUM_IDS = 2 ** ID_WIDTH;
    localparam logic [1:0]  SD_BOTH = 2'b11;

    logic [NUM_IDS-1:0]   arr_en_q, arr_en_d;
    logic [NUM_IDS-1:0]   arr_ws_q, arr_ws_d;
    logic [LVL_WIDTH-1:0] lvl_q [NUM_IDS];
    logic [LVL_WIDTH-1:0] lvl_d [NUM_IDS];

    logic                 up_valid_q, up_valid_d;
    logic [ID_WIDTH-1:0]  up_id_q, up_id_d;
    logic [LVL_WIDTH-1:0] up_lvl_q, up_lvl_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
    logic                 lvl_err_q, lvl_err_d;

    logic up_free, rsp_free, dn_fire;
    logic en_dup, ws_dup, pair;
    logic en_comp, ws_comp, en_to_rsp, ws_to_rsp;
    logic en_ok, ws_ok, en_ready, ws_ready;
    logic en_takes_rsp, en_takes_up;
    logic en_fire, ws_fire, en_load, ws_load;

    // Handshake decisions: dn owns RSP first, EN beats WS on either target.
    always_comb begin
        up_free   = !up_valid_q || up_ready_i;
        rsp_free  = !rsp_valid_q || rsp_ready_i;
        dn_fire   = dn_valid_i && rsp_free;

        en_dup    = arr_en_q[en_id_i];
        ws_dup    = arr_ws_q[ws_id_i];
        pair      = en_valid_i && ws_valid_i && (en_id_i == ws_id_i) && !en_dup && !ws_dup;
        en_comp   = pair || arr_ws_q[en_id_i];
        ws_comp   = pair || arr_en_q[ws_id_i];
        en_to_rsp = (en_lvl_i == '0);
        ws_to_rsp = (ws_lvl_i == '0);

        en_ok     = en_to_rsp ? (rsp_free && !dn_valid_i) : up_free;
        en_ready  = !en_dup && (!en_comp || en_ok);

        en_takes_rsp = en_valid_i && en_ready && en_comp && en_to_rsp;
        en_takes_up  = en_valid_i && en_ready && en_comp && !en_to_rsp;

        ws_ok     = ws_to_rsp ? (rsp_free && !dn_valid_i && !en_takes_rsp)
                              : (up_free && !en_takes_up);
        // A same-cycle pair is one completion, so both sides share EN's verdict.
        ws_ready  = pair ? en_ready : (!ws_dup && (!ws_comp || ws_ok));

        en_fire   = en_valid_i && en_ready;
        ws_fire   = ws_valid_i && ws_ready;
        en_load   = en_fire && en_comp;
        ws_load   = ws_fire && ws_comp && !pair;
    end

    // Arrival bookkeeping, level check and output register loads.
    always_comb begin
        arr_en_d    = arr_en_q;
        arr_ws_d    = arr_ws_q;
        lvl_d       = lvl_q;
        up_valid_d  = up_valid_q && !up_ready_i;
        up_id_d     = up_id_q;
        up_lvl_d    = up_lvl_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        rsp_id_d    = rsp_id_q;
        lvl_err_d   = 1'b0;

        if (en_fire) begin
            if (en_comp) begin
                arr_en_d[en_id_i] = 1'b0;
                arr_ws_d[en_id_i] = 1'b0;
            end else begin
                arr_en_d[en_id_i] = 1'b1;
                lvl_d[en_id_i]    = en_lvl_i;
            end
        end

        if (ws_fire) begin
            if (ws_comp) begin
                arr_en_d[ws_id_i] = 1'b0;
                arr_ws_d[ws_id_i] = 1'b0;
            end else begin
                arr_ws_d[ws_id_i] = 1'b1;
                lvl_d[ws_id_i]    = ws_lvl_i;
            end
        end

        if (en_load) begin
            if (pair) begin
                lvl_err_d = (en_lvl_i != ws_lvl_i);
            end else begin
                lvl_err_d = (en_lvl_i != lvl_q[en_id_i]);
            end
        end
        if (ws_load && (ws_lvl_i != lvl_q[ws_id_i])) begin
            lvl_err_d = 1'b1;
        end

        if (dn_fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = dn_id_i;
        end else if (en_load && en_to_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = en_id_i;
        end else if (ws_load && ws_to_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = ws_id_i;
        end

        if (en_load && !en_to_rsp) begin
            up_valid_d = 1'b1;
            up_id_d    = en_id_i;
            up_lvl_d   = en_lvl_i - LVL_WIDTH'(1);
        end else if (ws_load && !ws_to_rsp) begin
            up_valid_d = 1'b1;
            up_id_d    = ws_id_i;
            up_lvl_d   = ws_lvl_i - LVL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arr_en_q    <= '0;
            arr_ws_q    <= '0;
            for (int i = 0; i < NUM_IDS; i++) begin
                lvl_q[i] <= '0;
            end
            up_valid_q  <= 1'b0;
            up_id_q     <= '0;
            up_lvl_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            lvl_err_q   <= 1'b0;
        end else begin
            arr_en_q    <= arr_en_d;
            arr_ws_q    <= arr_ws_d;
            lvl_q       <= lvl_d;
            up_valid_q  <= up_valid_d;
            up_id_q     <= up_id_d;
            up_lvl_q    <= up_lvl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            lvl_err_q   <= lvl_err_d;
        end
    end

    assign en_ready_o  = en_ready;
    assign ws_ready_o  = ws_ready;
    assign dn_ready_o  = rsp_free;
    assign up_valid_o  = up_valid_q;
    assign up_id_o     = up_id_q;
    assign up_lvl_o    = up_lvl_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sd_o    = SD_BOTH;
    assign lvl_err_o   = lvl_err_q;

endmodule

// File: tb/tb_fractal_sync_merge.sv
// Directed bench for fractal_sync_merge: a per-cycle vector table followed by a
// hand-written duplicate-arrival / mid-operation reset sequence.
module tb_fractal_sync_merge;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_valid_i, ws_valid_i, dn_valid_i;
    logic [3:0] en_id_i, ws_id_i, dn_id_i;
    logic [2:0] en_lvl_i, ws_lvl_i;
    logic       up_ready_i, rsp_ready_i;
    logic       en_ready_o, ws_ready_o, dn_ready_o;
    logic       up_valid_o, rsp_valid_o, lvl_err_o;
    logic [3:0] up_id_o, rsp_id_o;
    logic [2:0] up_lvl_o;
    logic [1:0] rsp_sd_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fractal_sync_merge #(.ID_WIDTH(4), .LVL_WIDTH(3)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_valid_i (en_valid_i),
        .en_ready_o (en_ready_o),
        .en_id_i    (en_id_i),
        .en_lvl_i   (en_lvl_i),
        .ws_valid_i (ws_valid_i),
        .ws_ready_o (ws_ready_o),
        .ws_id_i    (ws_id_i),
        .ws_lvl_i   (ws_lvl_i),
        .up_valid_o (up_valid_o),
        .up_ready_i (up_ready_i),
        .up_id_o    (up_id_o),
        .up_lvl_o   (up_lvl_o),
        .dn_valid_i (dn_valid_i),
        .dn_ready_o (dn_ready_o),
        .dn_id_i    (dn_id_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_id_o   (rsp_id_o),
        .rsp_sd_o   (rsp_sd_o),
        .lvl_err_o  (lvl_err_o)
    );

    typedef struct {
        int en_v, en_id, en_lvl, ws_v, ws_id, ws_lvl, dn_v, dn_id, up_r, rsp_r;
        int x_en_r, x_ws_r, x_dn_r;
        int x_up_v, x_up_id, x_up_lvl, x_rsp_v, x_rsp_id, x_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(int en_v, int en_id, int en_lvl, int ws_v, int ws_id, int ws_lvl,
                               int dn_v, int dn_id, int up_r, int rsp_r,
                               int x_en_r, int x_ws_r, int x_dn_r,
                               int x_up_v, int x_up_id, int x_up_lvl,
                               int x_rsp_v, int x_rsp_id, int x_err);
        vec_t r;
        r.en_v = en_v;     r.en_id = en_id;     r.en_lvl = en_lvl;
        r.ws_v = ws_v;     r.ws_id = ws_id;     r.ws_lvl = ws_lvl;
        r.dn_v = dn_v;     r.dn_id = dn_id;
        r.up_r = up_r;     r.rsp_r = rsp_r;
        r.x_en_r = x_en_r; r.x_ws_r = x_ws_r;   r.x_dn_r = x_dn_r;
        r.x_up_v = x_up_v; r.x_up_id = x_up_id; r.x_up_lvl = x_up_lvl;
        r.x_rsp_v = x_rsp_v; r.x_rsp_id = x_rsp_id; r.x_err = x_err;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int en_v, input int en_id, input int en_lvl,
                                 input int ws_v, input int ws_id, input int ws_lvl,
                                 input int dn_v, input int dn_id, input int up_r, input int rsp_r);
        en_valid_i  = 1'(en_v);
        en_id_i     = 4'(en_id);
        en_lvl_i    = 3'(en_lvl);
        ws_valid_i  = 1'(ws_v);
        ws_id_i     = 4'(ws_id);
        ws_lvl_i    = 3'(ws_lvl);
        dn_valid_i  = 1'(dn_v);
        dn_id_i     = 4'(dn_id);
        up_ready_i  = 1'(up_r);
        rsp_ready_i = 1'(rsp_r);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Columns: en(v,id,lvl) ws(v,id,lvl) dn(v,id) up_r rsp_r | readies en ws dn |
        // up(v,id,lvl) rsp(v,id) err, the latter observed just after the clock edge.
        vecs.push_back(v(1,3,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 1,3,0, 0,0,  1,1, 1,1,1, 0,0,0,  1,3,  0));
        vecs.push_back(v(1,3,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 1,3,0, 0,0,  1,1, 1,1,1, 0,0,0,  1,3,  0));
        vecs.push_back(v(1,5,2, 1,5,2, 0,0,  1,1, 1,1,1, 1,5,1,  0,0,  0));
        vecs.push_back(v(1,6,1, 1,6,1, 0,0,  0,1, 0,0,1, 1,5,1,  0,0,  0));
        vecs.push_back(v(1,6,1, 1,6,1, 0,0,  0,1, 0,0,1, 1,5,1,  0,0,  0));
        vecs.push_back(v(1,6,1, 1,6,1, 0,0,  1,1, 1,1,1, 1,6,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(1,2,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 1,2,0, 1,9,  1,1, 1,0,1, 0,0,0,  1,9,  0));
        vecs.push_back(v(0,0,0, 1,2,0, 0,0,  1,1, 1,1,1, 0,0,0,  1,2,  0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(1,1,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 1,1,1, 0,0,  1,1, 1,1,1, 1,1,0,  0,0,  1));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 1,7,3, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(1,7,3, 1,8,0, 0,0,  1,1, 1,1,1, 1,7,2,  0,0,  0));
        vecs.push_back(v(1,8,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  1,8,  0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(1,10,1, 1,11,1, 0,0, 1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(1,11,1, 1,10,1, 0,0, 1,1, 1,0,1, 1,11,0, 0,0,  0));
        vecs.push_back(v(0,0,0, 1,10,1, 0,0,  1,1, 1,1,1, 1,10,0, 0,0,  0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));
        vecs.push_back(v(0,0,0, 0,0,0, 1,12, 1,0, 1,1,1, 0,0,0,  1,12, 0));
        vecs.push_back(v(0,0,0, 0,0,0, 1,13, 1,0, 1,1,0, 0,0,0,  1,12, 0));
        vecs.push_back(v(0,0,0, 0,0,0, 1,13, 1,1, 1,1,1, 0,0,0,  1,13, 0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,  1,1, 1,1,1, 0,0,0,  0,0,  0));

        #1;
        checkOutput("reset up_valid",  int'(up_valid_o),  0);
        checkOutput("reset rsp_valid", int'(rsp_valid_o), 0);
        checkOutput("reset lvl_err",   int'(lvl_err_o),   0);
        checkOutput("reset up_id",     int'(up_id_o),     0);
        checkOutput("reset up_lvl",    int'(up_lvl_o),    0);
        checkOutput("reset rsp_id",    int'(rsp_id_o),    0);
        checkOutput("reset rsp_sd",    int'(rsp_sd_o),    3);
        #11;
        rst_ni = 1'b1;
        step();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en_v, vecs[i].en_id, vecs[i].en_lvl,
                          vecs[i].ws_v, vecs[i].ws_id, vecs[i].ws_lvl,
                          vecs[i].dn_v, vecs[i].dn_id, vecs[i].up_r, vecs[i].rsp_r);
            #2;
            checkOutput($sformatf("v%0d en_ready", i), int'(en_ready_o), vecs[i].x_en_r);
            checkOutput($sformatf("v%0d ws_ready", i), int'(ws_ready_o), vecs[i].x_ws_r);
            checkOutput($sformatf("v%0d dn_ready", i), int'(dn_ready_o), vecs[i].x_dn_r);
            step();
            checkOutput($sformatf("v%0d up_valid", i),  int'(up_valid_o),  vecs[i].x_up_v);
            checkOutput($sformatf("v%0d rsp_valid", i), int'(rsp_valid_o), vecs[i].x_rsp_v);
            checkOutput($sformatf("v%0d lvl_err", i),   int'(lvl_err_o),   vecs[i].x_err);
            checkOutput($sformatf("v%0d rsp_sd", i),    int'(rsp_sd_o),    3);
            if (vecs[i].x_up_v != 0) begin
                checkOutput($sformatf("v%0d up_id", i),  int'(up_id_o),  vecs[i].x_up_id);
                checkOutput($sformatf("v%0d up_lvl", i), int'(up_lvl_o), vecs[i].x_up_lvl);
            end
            if (vecs[i].x_rsp_v != 0) begin
                checkOutput($sformatf("v%0d rsp_id", i), int'(rsp_id_o), vecs[i].x_rsp_id);
            end
        end

        // Fill both output registers under backpressure, then park a duplicate EN on ID 4.
        applyStimulus(1, 14, 2, 1, 14, 2, 1, 9, 0, 0);
        step();
        checkOutput("pre-reset up_valid",  int'(up_valid_o),  1);
        checkOutput("pre-reset rsp_valid", int'(rsp_valid_o), 1);
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("first en4 ready", int'(en_ready_o), 1);
        step();
        applyStimulus(1, 4, 0, 1, 15, 0, 0, 0, 0, 0);
        #2;
        checkOutput("dup en4 ready", int'(en_ready_o), 0);
        checkOutput("ws15 ready",    int'(ws_ready_o), 1);
        step();
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #2;
            checkOutput($sformatf("dup en4 wait%0d", k), int'(en_ready_o), 0);
            step();
        end

        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midreset up_valid",  int'(up_valid_o),  0);
        checkOutput("midreset rsp_valid", int'(rsp_valid_o), 0);
        checkOutput("midreset lvl_err",   int'(lvl_err_o),   0);
        checkOutput("midreset en4 ready", int'(en_ready_o),  1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #3;
        rst_ni = 1'b1;
        step();
        checkOutput("postreset up_valid",  int'(up_valid_o),  0);
        checkOutput("postreset rsp_valid", int'(rsp_valid_o), 0);

        applyStimulus(0, 0, 0, 1, 15, 0, 0, 0, 1, 1);
        #2;
        checkOutput("postreset ws15 ready", int'(ws_ready_o), 1);
        step();
        checkOutput("postreset ws15 no rsp", int'(rsp_valid_o), 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 1, 1);
        #2;
        checkOutput("postreset en4 ready", int'(en_ready_o), 1);
        step();
        checkOutput("postreset en4 no rsp", int'(rsp_valid_o), 0);
        applyStimulus(0, 0, 0, 1, 4, 0, 0, 0, 1, 1);
        step();
        checkOutput("postreset id4 rsp_valid", int'(rsp_valid_o), 1);
        checkOutput("postreset id4 rsp_id",    int'(rsp_id_o),    4);
        applyStimulus(1, 15, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        checkOutput("postreset id15 rsp_valid", int'(rsp_valid_o), 1);
        checkOutput("postreset id15 rsp_id",    int'(rsp_id_o),    15);
        checkOutput("postreset id15 lvl_err",   int'(lvl_err_o),   0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        checkOutput("final rsp_valid", int'(rsp_valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
